cvxif_dotp_copro: RTL and testbench
===================================

# cvxif_dotp_copro

CV-X-IF coprocessor that responds to the core's offload interface and executes custom-0 packed int8 dot-product instructions for the MNIST inference kernels. It accepts issue requests and holds them speculatively in an in-order queue. Each queued instruction executes only after the core commits it, then returns one result per accepted instruction on the result channel with backpressure. It sits on the core's CV-X-IF port, next to the integer pipeline.

## Interface
- XLEN, 32: register width; only 32 is supported.
- ID_WIDTH, 3: instruction id width.
- DEPTH, 4: number of issue-queue entries; must be a power of 2, ≥2.

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue handshake ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands
- issue_rs_valid_i  in  2  operand valid bits [1]=rs2, [0]=rs1
- issue_accept_o  out  1  instruction recognised and taken
- issue_writeback_o  out  1  instruction will write rd
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  ID_WIDTH  id being committed or killed
- commit_kill_i  in  1  1 = discard, 0 = execute
- result_valid_o  out  1  result valid
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  id of result
- result_data_o  out  XLEN  rd value
- result_rd_o  out  5  destination register
- result_we_o  out  1  write-enable for rd

## Operation
- Decode: opcode 7'h0B, funct3 3'b000. funct7 selects the operation:
  - 0 DOTP4: rd = Σ rs1.b[i]·rs2.b[i].
  - 1 DOTP4A: acc += dot; rd = new acc.
  - 2 CLRACC: acc = 0; we=0.
  - Any other encoding is rejected.
- Bytes are signed int8, with b[0] = bits 7:0. Products are 16-bit; the sum is 18-bit, sign-extended to XLEN. acc is XLEN bits and wraps modulo 2^XLEN.
- Issue response is combinational. It is valid in the cycle where issue_valid_i && issue_ready_o.
  - Rejected instruction: accept=0, writeback=0, and nothing is queued.
- issue_ready_o = !queue_full && (the instruction is not an accepted one, or issue_rs_valid_i == 2'b11).
  - An accepted instruction with missing operands stalls with ready=0.
- Queue entry contents: id, rd, op, rs1, rs2, committed flag, killed flag. Entries are in order.
- Commit: the entry whose id matches commit_id_i is flagged committed (kill=0) or killed (kill=1). A commit whose id matches no valid entry is ignored.
- Head processing, at most one entry per cycle:
  - A killed head is popped with no result.
  - A committed head executes when the result register is empty or is being drained in the same cycle. It then loads the result register, updates acc, and pops.
  - An uncommitted head waits.
- acc updates only at execution, so it is never speculative.
- The result register holds its value stable while result_valid_o && !result_ready_i.
- CLRACC returns a result with we=0 and data=0. Every accepted instruction that is not killed produces exactly one result.

## Timing
- Reset values:
  - issue_ready_o=1 (combinational; queue empty).
  - issue_accept_o=0, issue_writeback_o=0.
  - result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0.
  - acc=0, queue empty.
- Latency: head is committed in cycle N → result_valid_o rises in N+1.
  - Issue and commit of the same instruction in the same cycle is not supported; that commit is ignored.
- Throughput: one result per cycle when result_ready_i is held high.
- The full flag is registered. An issue arriving in the same cycle as a pop from a full queue still sees ready=0.
- Simultaneous commit and kill of different ids in one cycle cannot occur, because there is a single commit port.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- Asserting reset mid-operation discards all queued entries, the pending result, and acc.

## Configuration
- COPRO_ACC_EN defined: DOTP4A and CLRACC are decoded, and the acc register exists.
- COPRO_ACC_EN undefined: funct7 1 and 2 are rejected (accept=0), and there is no acc register. DOTP4 only.

## Test plan
- Reset: rst_ni low for 3 cycles → all outputs at their reset values, issue_ready_o=1.
- DOTP4 with rs1=0x01020304, rs2=0x05060708, rd=x5, id=2; commit id 2 at cycle N → cycle N+1: result_valid_o=1, data=0x00000046, rd=5, we=1, id=2.
- Signed: rs1=0xFFFFFFFF, rs2=0x7F7F7F7F → data=0xFFFFFE04.
- Accumulate (COPRO_ACC_EN):
  - DOTP4A ×2 with operands giving 0x46 each → data 0x46 then 0x8C.
  - CLRACC → we=0; a following DOTP4A → 0x46.
- Kill and full queue:
  - Fill all 4 entries → issue_ready_o=0.
  - Kill id 0 and commit ids 1–3 → exactly 3 results, in order 1, 2, 3, and acc is unaffected by id 0.
  - Hold result_ready_i=0 for 5 cycles → outputs stable.
- Reject: opcode 7'h33 → issue_ready_o=1, accept=0, no result. funct7=5 → rejected.

Source files
------------

// File: rtl/cvxif_dotp_copro.sv
// CV-X-IF coprocessor executing custom-0 packed int8 dot products from an in-order speculative issue queue.
// Define COPRO_ACC_EN to add the DOTP4A/CLRACC accumulator instructions and the acc register.

module cvxif_dotp_copro #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 3,
    parameter int DEPTH    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_DOTP4  = 2'd0,
        OP_DOTP4A = 2'd1,
        OP_CLRACC = 2'd2
    } op_e;

    logic                dec_ok;
    op_e                 dec_op;
    logic                push;
    logic                pop;
    logic                exec;
    logic                head_valid;
    logic                commit_hit_head;
    logic                head_killed;
    logic                head_committed;
    logic [IDX_W:0]      wr_ptr_q;
    logic [IDX_W:0]      rd_ptr_q;
    logic [IDX_W:0]      wr_ptr_n;
    logic [IDX_W:0]      rd_ptr_n;
    logic [IDX_W-1:0]    head_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                full_q;
    logic [DEPTH-1:0]    q_valid;
    logic [DEPTH-1:0]    q_committed;
    logic [DEPTH-1:0]    q_killed;
    logic [ID_WIDTH-1:0] q_id  [DEPTH];
    logic [4:0]          q_rd  [DEPTH];
    op_e                 q_op  [DEPTH];
    logic [XLEN-1:0]     q_rs1 [DEPTH];
    logic [XLEN-1:0]     q_rs2 [DEPTH];
    logic [XLEN-1:0]     dot_res;
    logic [XLEN-1:0]     exec_data;
    logic                exec_we;
    logic                unused_instr;
`ifdef COPRO_ACC_EN
    logic [XLEN-1:0]     acc_q;
    logic [XLEN-1:0]     acc_d;
`endif

    // Sum of four signed byte products; 18 bits is enough for the worst case, then sign-extend.
    function automatic logic [XLEN-1:0] dotp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [17:0] sum;
        logic signed [15:0] prod;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            prod = $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
            sum  = sum + {{2{prod[15]}}, prod};
        end
        return {{(XLEN-18){sum[17]}}, sum};
    endfunction

    assign unused_instr = ^issue_instr_i[24:15];

    always_comb begin
        dec_ok = 1'b0;
        dec_op = OP_DOTP4;
        if (issue_instr_i[6:0] == 7'h0B && issue_instr_i[14:12] == 3'b000) begin
            case (issue_instr_i[31:25])
                7'd0: dec_ok = 1'b1;
`ifdef COPRO_ACC_EN
                7'd1: begin dec_ok = 1'b1; dec_op = OP_DOTP4A; end
                7'd2: begin dec_ok = 1'b1; dec_op = OP_CLRACC; end
`endif
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Accepted instructions need both operands before handshaking; foreign ones are declined immediately.
    assign issue_ready_o     = !full_q && (!dec_ok || issue_rs_valid_i == 2'b11);
    assign issue_accept_o    = issue_valid_i && issue_ready_o && dec_ok;
    assign issue_writeback_o = issue_accept_o && (dec_op != OP_CLRACC);
    assign push              = issue_accept_o;

    assign head_idx = rd_ptr_q[IDX_W-1:0];
    assign wr_idx   = wr_ptr_q[IDX_W-1:0];

    // A commit aimed at the head takes effect this cycle, giving one-cycle commit-to-result latency.
    assign head_valid      = q_valid[head_idx];
    assign commit_hit_head = commit_valid_i && head_valid && (q_id[head_idx] == commit_id_i);
    assign head_killed     = q_killed[head_idx] || (commit_hit_head && commit_kill_i);
    assign head_committed  = q_committed[head_idx] || (commit_hit_head && !commit_kill_i);
    assign exec            = head_valid && !head_killed && head_committed && (!result_valid_o || result_ready_i);
    assign pop             = (head_valid && head_killed) || exec;

    assign wr_ptr_n = wr_ptr_q + (IDX_W+1)'(push);
    assign rd_ptr_n = rd_ptr_q + (IDX_W+1)'(pop);

    always_comb begin
        dot_res   = dotp(q_rs1[head_idx], q_rs2[head_idx]);
        exec_data = dot_res;
        exec_we   = 1'b1;
`ifdef COPRO_ACC_EN
        acc_d     = acc_q;
`endif
        case (q_op[head_idx])
`ifdef COPRO_ACC_EN
            OP_DOTP4A: begin
                acc_d     = acc_q + dot_res;
                exec_data = acc_d;
            end
`endif
            OP_CLRACC: begin
`ifdef COPRO_ACC_EN
                acc_d     = '0;
`endif
                exec_data = '0;
                exec_we   = 1'b0;
            end
            default: exec_data = dot_res;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            q_valid     <= '0;
            q_committed <= '0;
            q_killed    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            full_q   <= (wr_ptr_n[IDX_W] != rd_ptr_n[IDX_W]) &&
                        (wr_ptr_n[IDX_W-1:0] == rd_ptr_n[IDX_W-1:0]);
            if (commit_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_valid[i] && q_id[i] == commit_id_i) begin
                        if (commit_kill_i) begin
                            q_killed[i] <= 1'b1;
                        end else begin
                            q_committed[i] <= 1'b1;
                        end
                    end
                end
            end
            if (pop) begin
                q_valid[head_idx]     <= 1'b0;
                q_committed[head_idx] <= 1'b0;
                q_killed[head_idx]    <= 1'b0;
            end
            if (push) begin
                q_valid[wr_idx]     <= 1'b1;
                q_committed[wr_idx] <= 1'b0;
                q_killed[wr_idx]    <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_id[wr_idx]  <= issue_id_i;
            q_rd[wr_idx]  <= issue_instr_i[11:7];
            q_op[wr_idx]  <= dec_op;
            q_rs1[wr_idx] <= issue_rs1_i;
            q_rs2[wr_idx] <= issue_rs2_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
`ifdef COPRO_ACC_EN
            acc_q          <= '0;
`endif
        end else if (exec) begin
            result_valid_o <= 1'b1;
            result_id_o    <= q_id[head_idx];
            result_data_o  <= exec_data;
            result_rd_o    <= q_rd[head_idx];
            result_we_o    <= exec_we;
`ifdef COPRO_ACC_EN
            acc_q          <= acc_d;
`endif
        end else if (result_ready_i) begin
            result_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cvxif_dotp_copro.sv
// Self-checking bench for cvxif_dotp_copro: directed scenarios plus randomized issue/commit/kill rounds
// checked against an in-order scoreboard model. Honours COPRO_ACC_EN the same way the design does.

module tb_cvxif_dotp_copro;

    localparam int XLEN  = 32;
    localparam int IDW   = 3;
    localparam int DEPTH = 4;
`ifdef COPRO_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [31:0]     issue_instr_i = '0;
    logic [IDW-1:0]  issue_id_i = '0;
    logic [XLEN-1:0] issue_rs1_i = '0;
    logic [XLEN-1:0] issue_rs2_i = '0;
    logic [1:0]      issue_rs_valid_i = '0;
    logic            issue_accept_o;
    logic            issue_writeback_o;
    logic            commit_valid_i = 1'b0;
    logic [IDW-1:0]  commit_id_i = '0;
    logic            commit_kill_i = 1'b0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [IDW-1:0]  result_id_o;
    logic [XLEN-1:0] result_data_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    typedef struct {
        logic [2:0]  id;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        bit          kill;
    } ins_t;

    res_t        got[$];
    res_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] model_acc = '0;

    cvxif_dotp_copro #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd0, 5'd0, f3, rd, opc};
    endfunction

    function automatic int dot_ref(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int y;
            x = int'(byte'(a[8*i +: 8]));
            y = int'(byte'(b[8*i +: 8]));
            s += x * y;
        end
        return s;
    endfunction

    // Architectural meaning of each instruction, applied in program order to the model accumulator.
    function automatic res_t model_exec(input logic [2:0] id, input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic [31:0] d;
        d = 32'(dot_ref(a, b));
        r.id = id;
        r.rd = rd;
        r.we = 1'b1;
        r.data = d;
        if (f7 == 7'd1) begin
            model_acc = model_acc + d;
            r.data = model_acc;
        end else if (f7 == 7'd2) begin
            model_acc = '0;
            r.data = '0;
            r.we = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        if (result_valid_o && result_ready_i)
            got.push_back('{id: result_id_o, data: result_data_o, rd: result_rd_o, we: result_we_o});
        @(posedge clk_i);
        #1;
        if (rand_ready) result_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [2:0] id, input logic [31:0] a,
                            input logic [31:0] b, output logic acc, output logic wb);
        int n;
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs1_i      = a;
        issue_rs2_i      = b;
        issue_rs_valid_i = 2'b11;
        #1;
        n = 0;
        while (!issue_ready_o && n < 20) begin
            tick();
            n++;
        end
        acc = issue_accept_o;
        wb  = issue_writeback_o;
        if (!issue_ready_o) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL issue_timeout id=%0d ready stayed %b, required 1", id, issue_ready_o);
        end else begin
            tick();
        end
        issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_acc = '0;
        #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", issue_ready_o); end
        vectors++; if (issue_accept_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_accept got %b want 0", issue_accept_o); end
        vectors++; if (issue_writeback_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb got %b want 0", issue_writeback_o); end
        vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", result_valid_o); end
        vectors++; if (result_id_o !== '0) begin miscompares++; $display("[TB] FAIL reset_id got %0d want 0", result_id_o); end
        vectors++; if (result_data_o !== '0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", result_data_o); end
        vectors++; if (result_rd_o !== '0) begin miscompares++; $display("[TB] FAIL reset_rd got %0d want 0", result_rd_o); end
        vectors++; if (result_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we got %b want 0", result_we_o); end
        tick();
    endtask

    // Issue, commit one cycle later, then expect the result exactly one cycle after the commit.
    task automatic run_table(input string name, input logic [6:0] f7s[4], input logic [2:0] ids[4],
                             input logic [4:0] rds[4], input logic [31:0] as[4], input logic [31:0] bs[4],
                             input logic [31:0] want[4], input int n);
        logic acc, wb;
        res_t now, req;
        result_ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            got.delete();
            do_issue(mk_instr(f7s[k], 3'b000, rds[k], 7'h0B), ids[k], as[k], bs[k], acc, wb);
            req = model_exec(ids[k], f7s[k], rds[k], as[k], bs[k]);
            req.data = want[k];
            vectors++; if (acc !== 1'b1 || wb !== req.we) begin miscompares++; $display("[TB] FAIL %s_issue[%0d] accept/wb got %b%b want 1%b", name, k, acc, wb, req.we); end
            do_commit(ids[k], 1'b0);
            now = '{id: result_id_o, data: result_data_o, rd: result_rd_o, we: result_we_o};
            vectors++; if (result_valid_o !== 1'b1 || now !== req) begin miscompares++; $display("[TB] FAIL %s_result[%0d] got v=%b id=%0d data=%h rd=%0d we=%b want v=1 id=%0d data=%h rd=%0d we=%b", name, k, result_valid_o, now.id, now.data, now.rd, now.we, req.id, req.data, req.rd, req.we); end
            tick();
            vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_drain[%0d] valid got %b want 0", name, k, result_valid_o); end
        end
    endtask

    task automatic test_dotp4();
        run_table("dotp4", '{7'd0, 7'd0, 7'd0, 7'd0}, '{3'd2, 3'd3, 3'd0, 3'd0}, '{5'd5, 5'd7, 5'd0, 5'd0},
                  '{32'h01020304, 32'hFFFFFFFF, 32'h0, 32'h0}, '{32'h05060708, 32'h7F7F7F7F, 32'h0, 32'h0},
                  '{32'h00000046, 32'hFFFFFE04, 32'h0, 32'h0}, 2);
    endtask

    task automatic test_accumulate();
`ifdef COPRO_ACC_EN
        run_table("acc", '{7'd1, 7'd1, 7'd2, 7'd1}, '{3'd4, 3'd5, 3'd6, 3'd7}, '{5'd9, 5'd9, 5'd10, 5'd11},
                  '{32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304},
                  '{32'h05060708, 32'h05060708, 32'h05060708, 32'h05060708},
                  '{32'h00000046, 32'h0000008C, 32'h00000000, 32'h00000046}, 4);
`else
        logic acc, wb;
        result_ready_i = 1'b1;
        got.delete();
        for (int k = 1; k <= 2; k++) begin
            do_issue(mk_instr(7'(k), 3'b000, 5'd3, 7'h0B), 3'(k), 32'h01020304, 32'h05060708, acc, wb);
            vectors++; if (acc !== 1'b0 || wb !== 1'b0) begin miscompares++; $display("[TB] FAIL noacc_reject f7=%0d accept/wb got %b%b want 00", k, acc, wb); end
        end
        repeat (3) tick();
        vectors++; if (got.size() != 0) begin miscompares++; $display("[TB] FAIL noacc_results got %0d want 0", got.size()); end
`endif
    endtask

    task automatic test_reject();
        logic acc, wb;
        logic [31:0] instrs[3];
        instrs = '{mk_instr(7'd0, 3'b000, 5'd4, 7'h33), mk_instr(7'd5, 3'b000, 5'd4, 7'h0B),
                   mk_instr(7'd0, 3'b001, 5'd4, 7'h0B)};
        result_ready_i = 1'b1;
        got.delete();
        for (int k = 0; k < 3; k++) begin
            issue_valid_i = 1'b1; issue_instr_i = instrs[k]; issue_rs_valid_i = 2'b00;
            #1;
            vectors++; if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b100) begin miscompares++; $display("[TB] FAIL reject[%0d] ready/accept/wb got %b%b%b want 100", k, issue_ready_o, issue_accept_o, issue_writeback_o); end
            tick();
        end
        issue_instr_i = mk_instr(7'd0, 3'b000, 5'd4, 7'h0B);
        issue_rs_valid_i = 2'b01;
        #1;
        vectors++; if ({issue_ready_o, issue_accept_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL stall ready/accept got %b%b want 00", issue_ready_o, issue_accept_o); end
        tick();
        issue_valid_i = 1'b0;
        repeat (3) tick();
        vectors++; if (got.size() != 0 || result_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_results got %0d valid=%b want 0 results", got.size(), result_valid_o); end
        do_issue(mk_instr(7'd5, 3'b000, 5'd1, 7'h0B), 3'd1, '0, '0, acc, wb);
    endtask

    task automatic test_kill_full();
        logic acc, wb;
        ins_t ins[4];
        res_t now;
        int guard;
        rand_ready = 1'b0;
        result_ready_i = 1'b0;
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            ins[k] = '{id: 3'(k), f7: ACC_EN ? 7'd1 : 7'd0, rd: 5'(k + 12), a: $urandom, b: $urandom, kill: (k == 0)};
            do_issue(mk_instr(ins[k].f7, 3'b000, ins[k].rd, 7'h0B), ins[k].id, ins[k].a, ins[k].b, acc, wb);
            vectors++; if (acc !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_accept[%0d] got %b want 1", k, acc); end
        end
        for (int k = 1; k < 4; k++) exp_q.push_back(model_exec(ins[k].id, ins[k].f7, ins[k].rd, ins[k].a, ins[k].b));
        issue_valid_i = 1'b1; issue_instr_i = mk_instr(7'd0, 3'b000, 5'd1, 7'h0B); issue_id_i = 3'd4; issue_rs_valid_i = 2'b11;
        #1;
        vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready got %b want 0", issue_ready_o); end
        commit_valid_i = 1'b1; commit_id_i = 3'd0; commit_kill_i = 1'b1;
        #1;
        vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pop_ready got %b want 0", issue_ready_o); end
        tick();
        commit_valid_i = 1'b0;
        issue_valid_i = 1'b0;
        for (int k = 1; k < 4; k++) do_commit(3'(k), 1'b0);
        for (int c = 0; c < 6; c++) begin
            now = '{id: result_id_o, data: result_data_o, rd: result_rd_o, we: result_we_o};
            vectors++; if (result_valid_o !== 1'b1 || now !== exp_q[0]) begin miscompares++; $display("[TB] FAIL hold[%0d] got v=%b id=%0d data=%h want v=1 id=%0d data=%h", c, result_valid_o, now.id, now.data, exp_q[0].id, exp_q[0].data); end
            if (c < 5) tick();
        end
        result_ready_i = 1'b1;
        guard = 0;
        while (got.size() < 3 && guard < 20) begin tick(); guard++; end
        repeat (3) tick();
        vectors++; if (got.size() != 3) begin miscompares++; $display("[TB] FAIL kill_count got %0d want 3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("[TB] FAIL kill_result[%0d] got id=%0d data=%h rd=%0d we=%b want id=%0d data=%h rd=%0d we=%b", k, got[k].id, got[k].data, got[k].rd, got[k].we, exp_q[k].id, exp_q[k].data, exp_q[k].rd, exp_q[k].we); end
        end
    endtask

    task automatic test_random();
        logic acc, wb;
        ins_t pend[$];
        int order[$];
        logic [2:0] next_id;
        next_id = '0;
        for (int r = 0; r < 40; r++) begin
            got.delete();
            exp_q.delete();
            pend.delete();
            order.delete();
            rand_ready = 1'b0;
            result_ready_i = 1'b1;
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                int kind;
                logic [6:0] f7, opc;
                logic [2:0] f3;
                bit model_ok;
                ins_t t;
                kind = $urandom_range(0, 9);
                f7 = (kind == 1) ? 7'd5 : 7'($urandom_range(0, 2));
                f3 = (kind == 2) ? 3'd1 : 3'd0;
                opc = (kind == 0) ? 7'h33 : 7'h0B;
                model_ok = (kind >= 3) && (f7 == 7'd0 || ACC_EN);
                t = '{id: next_id, f7: f7, rd: 5'($urandom), a: $urandom, b: $urandom, kill: ($urandom_range(0, 3) == 0)};
                do_issue(mk_instr(f7, f3, t.rd, opc), t.id, t.a, t.b, acc, wb);
                vectors++; if (acc !== model_ok || wb !== (model_ok && f7 != 7'd2)) begin miscompares++; $display("[TB] FAIL rand_issue r=%0d k=%0d accept/wb got %b%b want %b%b", r, k, acc, wb, model_ok, model_ok && f7 != 7'd2); end
                if (model_ok) begin
                    pend.push_back(t);
                    next_id = next_id + 3'd1;
                end
            end
            foreach (pend[i]) begin
                order.push_back(i);
                if (!pend[i].kill) exp_q.push_back(model_exec(pend[i].id, pend[i].f7, pend[i].rd, pend[i].a, pend[i].b));
            end
            for (int i = order.size() - 1; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(0, i);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            rand_ready = 1'b1;
            foreach (order[i]) do_commit(pend[order[i]].id, pend[order[i]].kill);
            for (int g = 0; g < 200 && got.size() < exp_q.size(); g++) tick();
            rand_ready = 1'b0;
            result_ready_i = 1'b1;
            repeat (3) tick();
            vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL rand_count r=%0d got %0d want %0d", r, got.size(), exp_q.size()); end
            for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
                vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("[TB] FAIL rand_result r=%0d [%0d] got id=%0d data=%h rd=%0d we=%b want id=%0d data=%h rd=%0d we=%b", r, k, got[k].id, got[k].data, got[k].rd, got[k].we, exp_q[k].id, exp_q[k].data, exp_q[k].rd, exp_q[k].we); end
            end
        end
    endtask

    initial begin
        $display("[TB] starting cvxif_dotp_copro bench, ACC_EN=%0d", ACC_EN);
        test_reset();
        test_dotp4();
        test_accumulate();
        test_reject();
        test_kill_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
